peak_freq_calc: RTL

PEAK_FREQ_CALC -- requirements
Module: peak_freq_calc

---
 rtl/peak_freq_calc.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/peak_freq_calc.sv
// Peak-bin to frequency converter.
// Takes a per-frame FFT peak (power + bin index), folds the bin into the
// 0..N/2 range, multiplies by the sample rate with a serial shift-add
// multiplier and scales by 1/N. It outputs the per-frame frequency and an
// average over 2^AVG_LOG2 frames. Pulses that arrive while a conversion is
// running are dropped and counted.
module peak_freq_calc #(
    parameter logic [31:0] FS_HZ      = 32'd1_000_000,
    parameter int          N_LOG2     = 8,
    parameter int          AVG_LOG2   = 2,
    parameter logic [65:0] AMP_THRESH = 66'd1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        max_amp_valid,
    input  logic [65:0] max_amp,
    input  logic [15:0] max_amp_index,
    output logic [31:0] inst_freq_hz,
    output logic        inst_valid,
    output logic [31:0] freq_hz,
    output logic        freq_valid,
    output logic        signal_present,
    output logic        busy,
    output logic [7:0]  drop_cnt
);

    // The product holds at most (N/2)*FS_HZ, so 32+N_LOG2 bits is always enough.
    localparam int PW  = 32 + N_LOG2;
    localparam int AW  = 32 + AVG_LOG2;
    localparam int FCW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int CW  = $clog2(N_LOG2 + 1);

    localparam logic [N_LOG2-1:0] BIN_HALF = N_LOG2'(1) << (N_LOG2 - 1);
    localparam logic [FCW-1:0]    FC_LAST  = FCW'((1 << AVG_LOG2) - 1);
    localparam logic [CW-1:0]     MUL_LAST = CW'(N_LOG2 - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [N_LOG2-1:0]  mplier_q;
    logic [PW-1:0]      addend_q;
    logic [PW-1:0]      product_q;
    logic [CW-1:0]      mul_cnt_q;
    logic               amp_ok_q;
    logic [AW-1:0]      acc_q;
    logic [FCW-1:0]     frame_cnt_q;
    logic [31:0]        inst_freq_q;
    logic               inst_valid_q;
    logic [31:0]        freq_q;
    logic               freq_valid_q;
    logic               sig_present_q;
    logic [7:0]         drop_cnt_q;

    logic [N_LOG2-1:0]  bin_d;
    logic [N_LOG2-1:0]  folded_d;
    logic               amp_ok_d;
    logic [31:0]        result_d;
    logic [AW-1:0]      sum_d;
    logic [31:0]        freq_d;
    logic               unused_bits;

    // Bins above N/2 mirror the negative-frequency half; N-bin is -bin mod N.
    assign bin_d    = max_amp_index[N_LOG2-1:0];
    assign folded_d = (bin_d > BIN_HALF) ? (~bin_d + N_LOG2'(1)) : bin_d;
    assign amp_ok_d = (max_amp >= AMP_THRESH);

    // Divide by N is a plain truncating shift; a weak peak reports 0 Hz.
    assign result_d = amp_ok_q ? product_q[N_LOG2 +: 32] : 32'd0;
    assign sum_d    = acc_q + AW'(result_d);
    assign freq_d   = sum_d[AVG_LOG2 +: 32];

    // Index bits above the FFT length and the fractional product bits are discarded.
    assign unused_bits = ^{max_amp_index, product_q[N_LOG2-1:0]};

    // Control FSM, serial multiplier, averager and drop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            mplier_q      <= '0;
            addend_q      <= '0;
            product_q     <= '0;
            mul_cnt_q     <= '0;
            amp_ok_q      <= 1'b0;
            acc_q         <= '0;
            frame_cnt_q   <= '0;
            inst_freq_q   <= '0;
            inst_valid_q  <= 1'b0;
            freq_q        <= '0;
            freq_valid_q  <= 1'b0;
            sig_present_q <= 1'b0;
            drop_cnt_q    <= '0;
        end else begin
            inst_valid_q <= 1'b0;
            freq_valid_q <= 1'b0;

            if (max_amp_valid && (state_q != IDLE) && (drop_cnt_q != 8'hFF))
                drop_cnt_q <= drop_cnt_q + 8'd1;

            case (state_q)
                IDLE: begin
                    if (max_amp_valid) begin
                        mplier_q  <= folded_d;
                        addend_q  <= PW'(FS_HZ);
                        product_q <= '0;
                        mul_cnt_q <= '0;
                        amp_ok_q  <= amp_ok_d;
                        state_q   <= MUL;
                    end
                end
                MUL: begin
                    product_q <= product_q + (mplier_q[0] ? addend_q : '0);
                    addend_q  <= addend_q << 1;
                    mplier_q  <= mplier_q >> 1;
                    mul_cnt_q <= mul_cnt_q + CW'(1);
                    if (mul_cnt_q == MUL_LAST)
                        state_q <= DONE;
                end
                DONE: begin
                    inst_freq_q   <= result_d;
                    inst_valid_q  <= 1'b1;
                    sig_present_q <= amp_ok_q;
                    if (frame_cnt_q == FC_LAST) begin
                        freq_q       <= freq_d;
                        freq_valid_q <= 1'b1;
                        acc_q        <= '0;
                        frame_cnt_q  <= '0;
                    end else begin
                        acc_q       <= sum_d;
                        frame_cnt_q <= frame_cnt_q + FCW'(1);
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign inst_freq_hz   = inst_freq_q;
    assign inst_valid     = inst_valid_q;
    assign freq_hz        = freq_q;
    assign freq_valid     = freq_valid_q;
    assign signal_present = sig_present_q;
    assign busy           = (state_q != IDLE);
    assign drop_cnt       = drop_cnt_q;

endmodule
